// File: rtl/interrupt_request_unit.sv
// Interrupt front end for the MCU: INTR synchronizer, edge detect, pending latch,
// I flag with post-enable lockout, INT_R qualification. Optional macro: INT_COUNT_EN.
module interrupt_request_unit #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCKOUT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INTR,
    input  logic       I_SET,
    input  logic       I_CLR,
    input  logic       INT_ACK,
    output logic       INT_R,
    output logic       I_FLAG,
    output logic       INT_PENDING,
    output logic [7:0] INT_COUNT
);

    localparam int LCW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCKOUT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_q;
    logic                   sync_d;
    logic                   rise;
    logic                   pending;
    logic                   i_flag;
    logic                   set_accept;
    logic [LCW-1:0]         lock_cnt;

    assign sync_q     = sync_pipe[SYNC_STAGES-1];
    assign rise       = sync_q & ~sync_d;
    assign set_accept = I_SET & ~I_CLR & ~INT_ACK;

    // Chain and delay flop both reset low, so INTR held high across reset
    // release yields exactly one rise afterwards.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_pipe <= '0;
            sync_d    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], INTR};
            sync_d    <= sync_q;
        end
    end

    // A fresh edge wins over a simultaneous ACK so it is not lost.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            pending <= 1'b0;
        else if (rise)
            pending <= 1'b1;
        else if (INT_ACK)
            pending <= 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            i_flag <= 1'b0;
        else if (INT_ACK || I_CLR)
            i_flag <= 1'b0;
        else if (I_SET)
            i_flag <= 1'b1;
    end

    generate
        if (LOCKOUT_CYCLES > 0) begin : g_lock
            // Keeps INT_R low long enough for one instruction after RETIE/SEI.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET)
                    lock_cnt <= '0;
                else if (set_accept)
                    lock_cnt <= LOCK_LOAD;
                else if (lock_cnt != '0)
                    lock_cnt <= lock_cnt - 1'b1;
            end
        end else begin : g_nolock
            assign lock_cnt = '0;
        end
    endgenerate

`ifdef INT_COUNT_EN
    logic [7:0] int_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            int_cnt <= 8'h00;
        else if (INT_ACK && int_cnt != 8'hFF)
            int_cnt <= int_cnt + 8'd1;
    end

    assign INT_COUNT = int_cnt;
`else
    assign INT_COUNT = 8'h00;
`endif

    assign INT_R       = pending & i_flag & (lock_cnt == '0);
    assign I_FLAG      = i_flag;
    assign INT_PENDING = pending;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Bench for interrupt_request_unit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_interrupt_request_unit;

    localparam int S = 2;
    localparam int L = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       INTR = 1'b0;
    logic       I_SET = 1'b0;
    logic       I_CLR = 1'b0;
    logic       INT_ACK = 1'b0;
    logic       INT_R;
    logic       I_FLAG;
    logic       INT_PENDING;
    logic [7:0] INT_COUNT;

    int checks = 0;
    int errors = 0;

    interrupt_request_unit #(.SYNC_STAGES(S), .LOCKOUT_CYCLES(L)) dut (
        .CLK(CLK), .RESET(RESET), .INTR(INTR), .I_SET(I_SET), .I_CLR(I_CLR),
        .INT_ACK(INT_ACK), .INT_R(INT_R), .I_FLAG(I_FLAG),
        .INT_PENDING(INT_PENDING), .INT_COUNT(INT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Model: history of INTR samples taken at clock edges (index 0 = newest),
    // pending/flag per the priority rules, lockout as "edges since accepted I_SET".
    logic m_samp [0:S];
    logic m_pend, m_flag, m_rise;
    int   m_since, m_cnt;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i <= S; i++) m_samp[i] = 1'b0;
            m_pend = 0; m_flag = 0; m_since = L; m_cnt = 0;
        end else begin
            m_rise = m_samp[S-1] & ~m_samp[S];
            if (m_rise) m_pend = 1;
            else if (INT_ACK) m_pend = 0;
            if (INT_ACK || I_CLR) m_flag = 0;
            else if (I_SET) m_flag = 1;
            if (I_SET && !I_CLR && !INT_ACK) m_since = 0;
            else if (m_since < 1000) m_since++;
`ifdef INT_COUNT_EN
            if (INT_ACK && m_cnt < 255) m_cnt++;
`endif
            for (int i = S; i > 0; i--) m_samp[i] = m_samp[i-1];
            m_samp[0] = INTR;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            chk("model_int_r",   {7'd0, INT_R},       {7'd0, m_pend & m_flag & (m_since >= L)});
            chk("model_pending", {7'd0, INT_PENDING}, {7'd0, m_pend});
            chk("model_i_flag",  {7'd0, I_FLAG},      {7'd0, m_flag});
            chk("model_count",   INT_COUNT,           8'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_set();
        I_SET = 1'b1; tick(1); I_SET = 1'b0;
    endtask

    task automatic pulse_ack();
        INT_ACK = 1'b1; tick(1); INT_ACK = 1'b0;
    endtask

    localparam logic [7:0] CNT_MAX = `ifdef INT_COUNT_EN 8'd255 `else 8'd0 `endif;

    initial begin
        tick(3);
        RESET = 1'b0;
        chk("rst_count", INT_COUNT, 8'd0);
        chk("rst_flag", {7'd0, I_FLAG}, 8'd0);

        // Enable, no request
        tick(2);
        pulse_set();
        chk("en_flag", {7'd0, I_FLAG}, 8'd1);
        chk("en_int_r", {7'd0, INT_R}, 8'd0);
        chk("en_pend", {7'd0, INT_PENDING}, 8'd0);
        tick(3);

        // Edge latency and ACK, no re-trigger from held level
        INTR = 1'b1;
        tick(2);
        chk("lat_pend_early", {7'd0, INT_PENDING}, 8'd0);
        tick(1);
        chk("lat_pend", {7'd0, INT_PENDING}, 8'd1);
        chk("lat_int_r", {7'd0, INT_R}, 8'd1);
        pulse_ack();
        chk("ack_int_r", {7'd0, INT_R}, 8'd0);
        chk("ack_flag", {7'd0, I_FLAG}, 8'd0);
        chk("ack_pend", {7'd0, INT_PENDING}, 8'd0);
        tick(4);
        chk("held_no_retrig", {7'd0, INT_PENDING}, 8'd0);

        // Three edges while disabled collapse into one; lockout after I_SET
        INTR = 1'b0; tick(3);
        repeat (3) begin INTR = 1'b1; tick(2); INTR = 1'b0; tick(2); end
        tick(2);
        chk("multi_pend", {7'd0, INT_PENDING}, 8'd1);
        chk("multi_int_r", {7'd0, INT_R}, 8'd0);
        pulse_set();
        chk("lock_c0", {7'd0, INT_R}, 8'd0);
        tick(1);
        chk("lock_c1", {7'd0, INT_R}, 8'd0);
        tick(1);
        chk("lock_done", {7'd0, INT_R}, 8'd1);
        pulse_ack();
`ifdef INT_COUNT_EN
        chk("count_two", INT_COUNT, 8'd2);
`else
        chk("count_off", INT_COUNT, 8'd0);
`endif

        // Rise detected in the same cycle as ACK is retained
        pulse_set(); tick(3);
        INTR = 1'b1; tick(2);
        pulse_ack();
        chk("race_pend", {7'd0, INT_PENDING}, 8'd1);
        chk("race_flag", {7'd0, I_FLAG}, 8'd0);
        pulse_set(); tick(2);
        chk("race_int_r", {7'd0, INT_R}, 8'd1);
        pulse_ack();

        // I_SET with I_CLR clears
        pulse_set(); tick(3);
        chk("setclr_pre", {7'd0, I_FLAG}, 8'd1);
        I_SET = 1'b1; I_CLR = 1'b1; tick(1); I_SET = 1'b0; I_CLR = 1'b0;
        chk("setclr_flag", {7'd0, I_FLAG}, 8'd0);

        // Async reset mid-cycle with a live request
        INTR = 1'b0; tick(3);
        INTR = 1'b1; tick(4);
        pulse_set(); tick(3);
        chk("prerst_int_r", {7'd0, INT_R}, 8'd1);
        #3 RESET = 1'b1;
        #1;
        chk("rst_int_r", {7'd0, INT_R}, 8'd0);
        chk("rst_pend", {7'd0, INT_PENDING}, 8'd0);
        chk("rst_flag2", {7'd0, I_FLAG}, 8'd0);
        tick(2);
        RESET = 1'b0;
        tick(2);
        chk("rel_pend_early", {7'd0, INT_PENDING}, 8'd0);
        tick(1);
        chk("rel_pend", {7'd0, INT_PENDING}, 8'd1);
        chk("rel_int_r", {7'd0, INT_R}, 8'd0);
        INT_ACK = 1'b1; tick(256); INT_ACK = 1'b0;
        chk("count_sat", INT_COUNT, CNT_MAX);

        // Randomized traffic, model-checked every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) INTR = ~INTR;
            I_SET   = ($urandom_range(5) == 0);
            I_CLR   = ($urandom_range(9) == 0);
            INT_ACK = ($urandom_range(7) == 0);
            if ($urandom_range(499) == 0) begin
                #2 RESET = 1'b1;
                #4 RESET = 1'b0;
            end
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
